// File: rtl/cascade_counter_pkg.sv
// -----------------------------------------------------------------------------
// cascade_counter_pkg
//
// Purpose:
//   Shared constants and helpers for the cascaded modulo counter.
//   - Default geometry: 2 digits, 4 bits per digit, modulus 10 (two-digit BCD).
//   - digit_lsb(): bit position of a digit's least significant bit inside the
//     packed count/load_val buses. Digit i lives at [i*DIGIT_W +: DIGIT_W].
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package cascade_counter_pkg;

    localparam int DEFAULT_NUM_DIGITS = 2;
    localparam int DEFAULT_DIGIT_W    = 4;
    localparam int DEFAULT_DIGIT_MOD  = 10;

    // Digit 0 is the least significant digit and sits at the bottom of the bus.
    function automatic int digit_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/counter_digit.sv
// -----------------------------------------------------------------------------
// counter_digit
//
// Purpose:
//   One modulo-DIGIT_MOD digit of the cascaded counter. The digit steps up or
//   down when 'step' is high, wrapping at the ends of its range, and takes a
//   parallel load value (out-of-range values are forced to 0).
//   Priority on each edge: reset > load > step.
//
// Ports:
//   clk         in   clock, rising edge active
//   reset       in   synchronous active-high reset, digit goes to 0
//   step        in   advance this digit on this edge
//   up          in   1 = increment, 0 = decrement
//   load        in   parallel load strobe
//   load_digit  in   [DIGIT_W-1:0] value to load
//   value       out  [DIGIT_W-1:0] current digit value (registered)
//   at_max      out  value == DIGIT_MOD-1
//   at_zero     out  value == 0
// -----------------------------------------------------------------------------
module counter_digit
    import cascade_counter_pkg::*;
#(
    parameter int DIGIT_W   = DEFAULT_DIGIT_W,
    parameter int DIGIT_MOD = DEFAULT_DIGIT_MOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_zero
);

    // DIGIT_MOD may equal 2**DIGIT_W, which does not fit in DIGIT_W bits, so
    // the range check on load data is done one bit wider.
    localparam logic [DIGIT_W:0]   MOD_EXT = (DIGIT_W + 1)'(DIGIT_MOD);
    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(DIGIT_MOD - 1);

    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] value_next;
    logic [DIGIT_W-1:0] load_clamped;

    assign at_max  = (value_q == MAX_VAL);
    assign at_zero = (value_q == '0);
    assign value   = value_q;

    // Loading an illegal digit must never leave the digit outside its range.
    assign load_clamped = ({1'b0, load_digit} >= MOD_EXT) ? '0 : load_digit;

    // Next-value selection: load wins over step; a stepping digit wraps at
    // either end of its range.
    always_comb begin
        value_next = value_q;
        if (load) begin
            value_next = load_clamped;
        end else if (step) begin
            if (up) begin
                value_next = at_max ? '0 : value_q + 1'b1;
            end else begin
                value_next = at_zero ? MAX_VAL : value_q - 1'b1;
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_next;
        end
    end

endmodule

// File: rtl/cascade_counter.sv
// -----------------------------------------------------------------------------
// cascade_counter
//
// Purpose:
//   Up/down counter built from NUM_DIGITS cascaded modulo-DIGIT_MOD digits
//   (defaults give a two-digit BCD counter 00..99). Supports synchronous
//   parallel load, a combinational terminal-count flag and a registered
//   wrap pulse.
//
// Ports:
//   clk       in   clock, rising edge active
//   reset     in   synchronous active-high reset (count and wrap to 0)
//   en        in   count enable, one step per cycle
//   up        in   1 = increment, 0 = decrement
//   load      in   synchronous parallel load strobe (overrides en)
//   load_val  in   [NUM_DIGITS*DIGIT_W-1:0] load value, digit i at [i*DIGIT_W +: DIGIT_W]
//   count     out  [NUM_DIGITS*DIGIT_W-1:0] current count, same packing
//   tc        out  next enabled step wraps the whole counter (combinational)
//   wrap      out  one-cycle pulse: the counter wrapped on the previous edge
// -----------------------------------------------------------------------------
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int DIGIT_W    = DEFAULT_DIGIT_W,
    parameter int DIGIT_MOD  = DEFAULT_DIGIT_MOD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          up,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic                          tc,
    output logic                          wrap
);

    // A modulus below 2 is meaningless and one above 2**DIGIT_W cannot be
    // represented by a digit, so refuse to build either.
    if (DIGIT_MOD < 2 || DIGIT_MOD > (2 ** DIGIT_W)) begin : g_bad_param
        $error("cascade_counter: DIGIT_MOD (%0d) must be in 2..2**DIGIT_W (DIGIT_W=%0d)",
               DIGIT_MOD, DIGIT_W);
    end

    // chain_max[i]  : every digit below i is at DIGIT_MOD-1
    // chain_zero[i] : every digit below i is at 0
    // The top entry of each chain covers the whole counter and drives tc.
    logic [NUM_DIGITS:0]   chain_max;
    logic [NUM_DIGITS:0]   chain_zero;
    logic [NUM_DIGITS-1:0] digit_at_max;
    logic [NUM_DIGITS-1:0] digit_at_zero;
    logic [NUM_DIGITS-1:0] digit_step;
    logic                  wrap_q;

    assign chain_max[0]  = 1'b1;
    assign chain_zero[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int LSB = digit_lsb(i, DIGIT_W);

        assign chain_max[i+1]  = chain_max[i]  & digit_at_max[i];
        assign chain_zero[i+1] = chain_zero[i] & digit_at_zero[i];

        // A digit steps only when every lower digit is about to carry/borrow.
        assign digit_step[i] = en & (up ? chain_max[i] : chain_zero[i]);

        counter_digit #(
            .DIGIT_W   (DIGIT_W),
            .DIGIT_MOD (DIGIT_MOD)
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .step       (digit_step[i]),
            .up         (up),
            .load       (load),
            .load_digit (load_val[LSB +: DIGIT_W]),
            .value      (count[LSB +: DIGIT_W]),
            .at_max     (digit_at_max[i]),
            .at_zero    (digit_at_zero[i])
        );
    end

    // A load cancels stepping on this edge, so it also cancels terminal count;
    // that is what keeps wrap low on the cycle after a load.
    assign tc = en & ~load & (up ? chain_max[NUM_DIGITS] : chain_zero[NUM_DIGITS]);

    // wrap is tc delayed by one edge, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// -----------------------------------------------------------------------------
// tb_cascade_counter
//
// Purpose:
//   Self-checking bench for cascade_counter. A default (2-digit BCD) instance
//   is exercised with a table of directed vectors plus hand-written runs for
//   full up/down wrap; a 3-digit modulus-11 instance is run through a full
//   1331-step cycle.
// -----------------------------------------------------------------------------
module tb_cascade_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic        tc;
    logic        wrap;

    logic        reset3;
    logic        en3;
    logic        up3;
    logic        load3;
    logic [11:0] load_val3;
    logic [11:0] count3;
    logic        tc3;
    logic        wrap3;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] lv;
        logic       chk_tc;
        logic       exp_tc;
        logic [7:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    cascade_counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    cascade_counter #(
        .NUM_DIGITS (3),
        .DIGIT_W    (4),
        .DIGIT_MOD  (11)
    ) dut3 (
        .clk      (clk),
        .reset    (reset3),
        .en       (en3),
        .up       (up3),
        .load     (load3),
        .load_val (load_val3),
        .count    (count3),
        .tc       (tc3),
        .wrap     (wrap3)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic u, input logic [7:0] v);
        reset    = r;
        load     = l;
        en       = e;
        up       = u;
        load_val = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic l, input logic e, input logic u,
                          input logic [7:0] v, input logic ct, input logic et,
                          input logic [7:0] ec, input logic ew);
        vec_t t;
        t.rst = r; t.ld = l; t.en = e; t.up = u; t.lv = v;
        t.chk_tc = ct; t.exp_tc = et; t.exp_count = ec; t.exp_wrap = ew;
        vecs.push_back(t);
    endtask

    function automatic logic [7:0] bcd2(input int k);
        logic [7:0] r;
        r[7:4] = 4'(k / 10);
        r[3:0] = 4'(k % 10);
        return r;
    endfunction

    function automatic logic [11:0] mod11x3(input int n);
        logic [11:0] r;
        r[3:0]  = 4'(n % 11);
        r[7:4]  = 4'((n / 11) % 11);
        r[11:8] = 4'(n / 121);
        return r;
    endfunction

    initial begin
        int wraps;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        reset3 = 1'b1; en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; load_val3 = '0;

        // Sequential vectors: each one continues from the state left by the last.
        // rst  ld    en    up    lv     chkTc tc    count  wrap
        addVec(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); // reset
        addVec(1'b0, 1'b1, 1'b1, 1'b1, 8'h47, 1'b1, 1'b0, 8'h47, 1'b0); // load, no step
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0); // bad low digit
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0); // both bad
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h19, 1'b1, 1'b0, 8'h19, 1'b0);
        for (int h = 0; h < 5; h++)
            addVec(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h19, 1'b0); // hold
        addVec(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0); // carry
        addVec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h19, 1'b0); // borrow
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h58, 1'b1, 1'b0, 8'h58, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b1, 8'h47, 1'b1, 1'b0, 8'h00, 1'b0); // reset wins
        addVec(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b0);
        addVec(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1); // up wrap
        addVec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1); // down wrap
        addVec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h98, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b0); // load kills tc
        addVec(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        addVec(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0);
        addVec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h39, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 1'b0);
        addVec(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0); // reset clears wrap

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
            #1;
            if (vecs[i].chk_tc)
                checkOutput($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            tick();
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // Full up run: 00..99 in BCD, tc only at 99, single wrap pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 100; k++) begin
            #1;
            checkOutput($sformatf("up%0d count", k), 32'(count), 32'(bcd2(k)));
            checkOutput($sformatf("up%0d tc", k), 32'(tc), 32'(k == 99));
            tick();
            checkOutput($sformatf("up%0d wrap", k), 32'(wrap), 32'(k == 99));
        end
        checkOutput("up end count", 32'(count), 32'h00);
        tick();
        checkOutput("up wrap cleared", 32'(wrap), 32'h0);
        checkOutput("up after wrap count", 32'(count), 32'h01);

        // Down run from reset: 00 -> 99 -> 98.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("dn tc at 00", 32'(tc), 32'h1);
        tick();
        checkOutput("dn count 99", 32'(count), 32'h99);
        checkOutput("dn wrap pulse", 32'(wrap), 32'h1);
        checkOutput("dn tc at 99", 32'(tc), 32'h0);
        tick();
        checkOutput("dn count 98", 32'(count), 32'h98);
        checkOutput("dn wrap low", 32'(wrap), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Three digits, modulus 11: full 1331-step cycle with one wrap.
        tick();
        reset3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        wraps = 0;
        for (int n = 0; n < 1331; n++) begin
            #1;
            checkOutput($sformatf("m11 %0d count", n), 32'(count3), 32'(mod11x3(n)));
            checkOutput($sformatf("m11 %0d tc", n), 32'(tc3), 32'(n == 1330));
            tick();
            if (wrap3) wraps++;
        end
        checkOutput("m11 end count", 32'(count3), 32'h000);
        checkOutput("m11 wrap count", 32'(wraps), 32'd1);
        en3 = 1'b0;
        tick();
        checkOutput("m11 wrap cleared", 32'(wrap3), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
